// File: rtl/nand_arb_pkg.sv
// Shared definitions for the NAND request arbiter.
//   arb_state_e        : FSM encoding (IDLE=0, ISSUE=1, WAIT=2, COMPLETE=3)
//   TimeoutCycDefault  : default watchdog limit in out_clk cycles
//   rr_wrap()          : (base + off) mod n, used by the round-robin search
package nand_arb_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StIssue    = 2'd1,
      StWait     = 2'd2,
      StComplete = 2'd3
   } arb_state_e;

   localparam int unsigned TimeoutCycDefault = 50000;

   function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/nand_req_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   pending_i : request vector to search
//   rr_ptr_i  : index where the search starts (wraps at N_REQ-1)
//   grant_o   : one-hot winner (zero when nothing pending)
//   idx_o     : index of the winner
//   valid_o   : at least one request pending
module nand_req_arbiter_rr_picker
   import nand_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] pending_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] pos;

   // Walk offsets from farthest to nearest so the nearest set bit is written last and wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      pos     = '0;
      valid_o = |pending_i;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = IDX_W'(rr_wrap(32'(rr_ptr_i), 32'(k), N_REQ));
         if (pending_i[pos]) begin
            grant_o      = '0;
            grant_o[pos] = 1'b1;
            idx_o        = pos;
         end
      end
   end

endmodule

// File: rtl/nand_req_arbiter.sv
// Round-robin arbiter placing single-cycle requests onto one shared NAND engine.
//   out_clk      : clock, all logic on posedge
//   rst          : asynchronous active-high reset
//   req_pulse_i  : one-cycle request pulse per requester
//   op_done_i    : engine completion pulse (only honoured in WAIT)
//   op_start_o   : one-cycle start strobe to the engine
//   op_sel_o     : one-hot owner, held from grant until return to IDLE
//   grant_done_o : one-cycle completion pulse to the owner
//   grant_err_o  : coincident with grant_done_o when the op timed out
//   pending_o    : latched, not-yet-granted requests
//   busy_o       : FSM not in IDLE
module nand_req_arbiter
   import nand_arb_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault,
   parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC)
) (
   input  logic             out_clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_pulse_i,
   input  logic             op_done_i,
   output logic             op_start_o,
   output logic [N_REQ-1:0] op_sel_o,
   output logic [N_REQ-1:0] grant_done_o,
   output logic             grant_err_o,
   output logic [N_REQ-1:0] pending_o,
   output logic             busy_o
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] op_sel_q, op_sel_d;
   logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [N_REQ-1:0] grant_clr;

   logic [N_REQ-1:0] pick_onehot;
   logic [IdxW-1:0]  pick_idx;
   logic             pick_valid;

   nand_req_arbiter_rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IdxW)
   ) u_rr_picker (
      .pending_i (pending_q),
      .rr_ptr_i  (rr_ptr_q),
      .grant_o   (pick_onehot),
      .idx_o     (pick_idx),
      .valid_o   (pick_valid)
   );

   always_comb begin
      state_d   = state_q;
      op_sel_d  = op_sel_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      grant_clr = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               op_sel_d  = pick_onehot;
               grant_clr = pick_onehot;
               rr_ptr_d  = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StWait;
         end
         StWait: begin
            // A done arriving on the last allowed cycle still counts as success.
            if (op_done_i) begin
               err_d   = 1'b0;
               state_d = StComplete;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = StComplete;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StComplete: begin
            op_sel_d = '0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // New pulse beats the grant clear, so a same-edge re-request is kept.
      pending_d = (pending_q & ~grant_clr) | req_pulse_i;
   end

   always_ff @(posedge out_clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= '0;
         op_sel_q  <= '0;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         op_sel_q  <= op_sel_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   // Moore outputs from registered state only.
   always_comb begin
      op_start_o   = (state_q == StIssue);
      busy_o       = (state_q != StIdle);
      grant_done_o = (state_q == StComplete) ? op_sel_q : '0;
      grant_err_o  = (state_q == StComplete) && err_q;
      op_sel_o     = op_sel_q;
      pending_o    = pending_q;
   end

endmodule
